alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_multicycle_if.sv | 22 ++
 rtl/alu_multicycle.sv | 198 +++++++++++++++++++
 tb/tb_alu_multicycle.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/alu_multicycle_if.sv
// Handshake and data bundle between the ALU and its requester.
// Signal suffixes are written from the ALU's point of view.
interface alu_multicycle_if;
  logic        start_i;
  logic [3:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [31:0] result_o;
  logic        zero_o;
  logic        busy_o;
  logic        done_o;

  modport master (
    output start_i, op_i, a_i, b_i,
    input  result_o, zero_o, busy_o, done_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i,
    output result_o, zero_o, busy_o, done_o
  );
endinterface

// File: rtl/alu_multicycle.sv
// Multicycle ALU.
// - Single-cycle ops complete at the accepting edge.
// - MUL, DIVU and REMU (divisor non-zero) iterate for 32 cycles.
//   MUL uses shift-add; DIVU/REMU use restoring division.
// - Division by zero takes the single-cycle path with fixed results.
module alu_multicycle (
  input  logic            clk_i,
  input  logic            reset_i,
  alu_multicycle_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [3:0]  op_q;
  logic [31:0] acc_q;      // product accumulator, or partial remainder
  logic [31:0] opa_q;      // multiplicand, or dividend shifting into quotient
  logic [31:0] opb_q;      // multiplier, or divisor
  logic [31:0] result_q;
  logic        zero_q;
  logic        done_q;
  logic        busy_s;

  logic        is_iter_s;
  logic [31:0] single_res_s;
  logic [31:0] mul_acc_s;
  logic [31:0] rem_shift_s;
  logic        div_ge_s;
  logic [31:0] rem_next_s;
  logic [31:0] quo_next_s;
  logic [31:0] final_res_s;

  // Classify the requested op: does it need the iterative path?
  always_comb begin
    is_iter_s = 1'b0;
    if (bus.op_i == OP_MUL) begin
      is_iter_s = 1'b1;
    end else if ((bus.op_i == OP_DIVU) || (bus.op_i == OP_REMU)) begin
      is_iter_s = (bus.b_i != 32'd0);
    end else begin
      is_iter_s = 1'b0;
    end
  end

  // Compute the result of every op that completes in a single cycle.
  always_comb begin
    single_res_s = 32'd0;
    case (bus.op_i)
      OP_ADD:  single_res_s = bus.a_i + bus.b_i;
      OP_SUB:  single_res_s = bus.a_i - bus.b_i;
      OP_AND:  single_res_s = bus.a_i & bus.b_i;
      OP_OR:   single_res_s = bus.a_i | bus.b_i;
      OP_XOR:  single_res_s = bus.a_i ^ bus.b_i;
      OP_SLL:  single_res_s = bus.a_i << bus.b_i[4:0];
      OP_SRL:  single_res_s = bus.a_i >> bus.b_i[4:0];
      OP_SRA:  single_res_s = $unsigned($signed(bus.a_i) >>> bus.b_i[4:0]);
      OP_SLT:  single_res_s = {31'd0, ($signed(bus.a_i) < $signed(bus.b_i))};
      OP_SLTU: single_res_s = {31'd0, (bus.a_i < bus.b_i)};
      // Only reached here with a zero divisor.
      OP_DIVU: single_res_s = 32'hFFFF_FFFF;
      OP_REMU: single_res_s = bus.a_i;
      default: single_res_s = 32'd0;
    endcase
  end

  // Compute one multiply step and one restoring-division step, plus the
  // final result.
  always_comb begin
    mul_acc_s   = opb_q[0] ? (acc_q + opa_q) : acc_q;
    rem_shift_s = {acc_q[30:0], opa_q[31]};
    // The shifted remainder may carry into bit 32 (acc_q[31]); it then
    // always exceeds the divisor. The 32-bit difference is still exact.
    div_ge_s    = acc_q[31] | (rem_shift_s >= opb_q);
    rem_next_s  = div_ge_s ? (rem_shift_s - opb_q) : rem_shift_s;
    quo_next_s  = {opa_q[30:0], div_ge_s};
    case (op_q)
      OP_MUL:  final_res_s = mul_acc_s;
      OP_DIVU: final_res_s = quo_next_s;
      OP_REMU: final_res_s = rem_next_s;
      default: final_res_s = 32'd0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: accept iterative work in IDLE, leave RUN after the
  // 32nd step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i && is_iter_s) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q == 5'd31) begin
          state_d = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: BUSY follows the RUN state.
  always_comb begin
    busy_s = 1'b0;
    case (state_q)
      RUN:     busy_s = 1'b1;
      default: busy_s = 1'b0;
    endcase
  end

  // Datapath: latch operands, iterate, and register the result/ZERO/DONE.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q    <= 5'd0;
      op_q     <= 4'd0;
      acc_q    <= 32'd0;
      opa_q    <= 32'd0;
      opb_q    <= 32'd0;
      result_q <= 32'd0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            if (is_iter_s) begin
              op_q  <= bus.op_i;
              opa_q <= bus.a_i;
              opb_q <= bus.b_i;
              acc_q <= 32'd0;
              cnt_q <= 5'd0;
            end else begin
              result_q <= single_res_s;
              zero_q   <= (single_res_s == 32'd0);
              done_q   <= 1'b1;
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q + 5'd1;
          if (op_q == OP_MUL) begin
            acc_q <= mul_acc_s;
            opa_q <= {opa_q[30:0], 1'b0};
            opb_q <= {1'b0, opb_q[31:1]};
          end else begin
            acc_q <= rem_next_s;
            opa_q <= quo_next_s;
          end
          if (cnt_q == 5'd31) begin
            result_q <= final_res_s;
            zero_q   <= (final_res_s == 32'd0);
            done_q   <= 1'b1;
            cnt_q    <= 5'd0;
          end
        end
        default: begin
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result_o = result_q;
  assign bus.zero_o   = zero_q;
  assign bus.busy_o   = busy_s;
  assign bus.done_o   = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle.
module tb_alu_multicycle;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  alu_multicycle_if bus_if ();

  alu_multicycle dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus_if.start_i = 1'b1;
    bus_if.op_i    = op;
    bus_if.a_i     = a;
    bus_if.b_i     = b;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(4'd0, 32'd1, 32'd1);
    @(posedge clk); #1;
    n_checks++; if (bus_if.result_o !== 32'd0) begin n_fails++; $display("FAIL reset_result got %h exp %h", bus_if.result_o, 32'd0); end
    n_checks++; if (bus_if.zero_o !== 1'b1) begin n_fails++; $display("FAIL reset_zero got %b exp 1", bus_if.zero_o); end
    n_checks++; if (bus_if.busy_o !== 1'b0) begin n_fails++; $display("FAIL reset_busy got %b exp 0", bus_if.busy_o); end
    n_checks++; if (bus_if.done_o !== 1'b0) begin n_fails++; $display("FAIL reset_done got %b exp 0", bus_if.done_o); end
    reset = 1'b0;
    bus_if.start_i = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus_if.done_o !== 1'b0) begin n_fails++; $display("FAIL reset_start_ignored got done %b exp 0", bus_if.done_o); end
  endtask

  task automatic test_single();
    logic [3:0]  ops  [14] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd13, 4'd11, 4'd12};
    logic [31:0] as   [14] = '{32'h7FFF_FFFF, 32'd5, 32'd3, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0,
                               32'd1, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5,
                               32'h0000_1234, 32'h0000_1234};
    logic [31:0] bs   [14] = '{32'd1, 32'd5, 32'd5, 32'h0FF0_0FF0, 32'h0FF0_0FF0, 32'h0FF0_0FF0,
                               32'h0000_001F, 32'h0000_0024, 32'h0000_0021, 32'd0, 32'd0, 32'd5,
                               32'd0, 32'd0};
    logic [31:0] exps [14] = '{32'h8000_0000, 32'd0, 32'hFFFF_FFFE, 32'h00F0_00F0, 32'hFFF0_FFF0, 32'hFF00_FF00,
                               32'h8000_0000, 32'h0800_0000, 32'hC000_0000, 32'd1, 32'd0, 32'd0,
                               32'hFFFF_FFFF, 32'h0000_1234};
    logic        expz;
    for (int i = 0; i < 14; i++) begin
      expz = (exps[i] == 32'd0);
      drive(ops[i], as[i], bs[i]);
      @(posedge clk); #1;
      bus_if.start_i = 1'b0;
      n_checks++; if (bus_if.done_o !== 1'b1) begin n_fails++; $display("FAIL single_done[%0d] got %b exp 1", i, bus_if.done_o); end
      n_checks++; if (bus_if.busy_o !== 1'b0) begin n_fails++; $display("FAIL single_busy[%0d] got %b exp 0", i, bus_if.busy_o); end
      n_checks++; if (bus_if.result_o !== exps[i]) begin n_fails++; $display("FAIL single_result[%0d] op %0d got %h exp %h", i, ops[i], bus_if.result_o, exps[i]); end
      n_checks++; if (bus_if.zero_o !== expz) begin n_fails++; $display("FAIL single_zero[%0d] got %b exp %b", i, bus_if.zero_o, expz); end
      @(posedge clk); #1;
      n_checks++; if (bus_if.done_o !== 1'b0) begin n_fails++; $display("FAIL single_pulse[%0d] got done %b exp 0", i, bus_if.done_o); end
      n_checks++; if (bus_if.result_o !== exps[i]) begin n_fails++; $display("FAIL single_hold[%0d] got %h exp %h", i, bus_if.result_o, exps[i]); end
    end
  endtask

  task automatic test_iterative();
    logic [3:0]  ops  [6] = '{4'd10, 4'd10, 4'd10, 4'd11, 4'd12, 4'd11};
    logic [31:0] as   [6] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h0001_0000, 32'd100, 32'd100, 32'hFFFF_FFFF};
    logic [31:0] bs   [6] = '{32'd2, 32'h0000_0010, 32'h0001_0000, 32'd7, 32'd7, 32'd1};
    logic [31:0] exps [6] = '{32'hFFFF_FFFE, 32'h2345_6780, 32'd0, 32'd14, 32'd2, 32'hFFFF_FFFF};
    int   n;
    int   busy_cnt;
    logic got;
    logic expz;
    for (int i = 0; i < 6; i++) begin
      expz = (exps[i] == 32'd0);
      drive(ops[i], as[i], bs[i]);
      @(posedge clk); #1;
      bus_if.start_i = 1'b0;
      bus_if.op_i    = 4'd0;
      bus_if.a_i     = ~as[i];
      bus_if.b_i     = ~bs[i];
      n_checks++; if (bus_if.busy_o !== 1'b1) begin n_fails++; $display("FAIL iter_busy_start[%0d] got %b exp 1", i, bus_if.busy_o); end
      n_checks++; if (bus_if.done_o !== 1'b0) begin n_fails++; $display("FAIL iter_done_early[%0d] got %b exp 0", i, bus_if.done_o); end
      n = 0;
      busy_cnt = 0;
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        @(posedge clk); #1;
        n++;
        if (bus_if.done_o === 1'b1) begin
          got = 1'b1;
        end else begin
          if (bus_if.busy_o === 1'b1) busy_cnt++;
          bus_if.a_i = $urandom;
          bus_if.b_i = $urandom;
          bus_if.op_i = 4'($urandom_range(0, 15));
        end
      end
      n_checks++; if (got !== 1'b1) begin n_fails++; $display("FAIL iter_timeout[%0d] got no done exp done within 40 cycles", i); end
      n_checks++; if (n != 32) begin n_fails++; $display("FAIL iter_latency[%0d] got %0d exp 32", i, n); end
      n_checks++; if (busy_cnt != 31) begin n_fails++; $display("FAIL iter_busy_cycles[%0d] got %0d exp 31", i, busy_cnt); end
      n_checks++; if (bus_if.busy_o !== 1'b0) begin n_fails++; $display("FAIL iter_busy_end[%0d] got %b exp 0", i, bus_if.busy_o); end
      n_checks++; if (bus_if.result_o !== exps[i]) begin n_fails++; $display("FAIL iter_result[%0d] op %0d got %h exp %h", i, ops[i], bus_if.result_o, exps[i]); end
      n_checks++; if (bus_if.zero_o !== expz) begin n_fails++; $display("FAIL iter_zero[%0d] got %b exp %b", i, bus_if.zero_o, expz); end
      @(posedge clk); #1;
      n_checks++; if (bus_if.done_o !== 1'b0) begin n_fails++; $display("FAIL iter_pulse[%0d] got %b exp 0", i, bus_if.done_o); end
      n_checks++; if (bus_if.result_o !== exps[i]) begin n_fails++; $display("FAIL iter_hold[%0d] got %h exp %h", i, bus_if.result_o, exps[i]); end
    end
  endtask

  task automatic test_ignore_start();
    int dones;
    logic [31:0] res_at_done;
    dones = 0;
    res_at_done = 32'd0;
    drive(4'd10, 32'd6, 32'd7);
    @(posedge clk); #1;
    bus_if.start_i = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 5) drive(4'd0, 32'd1, 32'd1);
      if (c == 9) bus_if.start_i = 1'b0;
      @(posedge clk); #1;
      if (bus_if.done_o === 1'b1) begin
        dones++;
        res_at_done = bus_if.result_o;
      end
    end
    n_checks++; if (dones != 1) begin n_fails++; $display("FAIL ignore_start_dones got %0d exp 1", dones); end
    n_checks++; if (res_at_done !== 32'd42) begin n_fails++; $display("FAIL ignore_start_result got %h exp %h", res_at_done, 32'd42); end
    n_checks++; if (bus_if.result_o !== 32'd42) begin n_fails++; $display("FAIL ignore_start_hold got %h exp %h", bus_if.result_o, 32'd42); end
  endtask

  task automatic test_reset_abort();
    int dones;
    dones = 0;
    drive(4'd10, 32'd3, 32'd3);
    @(posedge clk); #1;
    bus_if.start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++; if (bus_if.busy_o !== 1'b0) begin n_fails++; $display("FAIL abort_busy got %b exp 0", bus_if.busy_o); end
    n_checks++; if (bus_if.result_o !== 32'd0) begin n_fails++; $display("FAIL abort_result got %h exp %h", bus_if.result_o, 32'd0); end
    n_checks++; if (bus_if.zero_o !== 1'b1) begin n_fails++; $display("FAIL abort_zero got %b exp 1", bus_if.zero_o); end
    n_checks++; if (bus_if.done_o !== 1'b0) begin n_fails++; $display("FAIL abort_done got %b exp 0", bus_if.done_o); end
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus_if.done_o === 1'b1) dones++;
    end
    n_checks++; if (dones != 0) begin n_fails++; $display("FAIL abort_no_done got %0d dones exp 0", dones); end
  endtask

  task automatic test_back_to_back();
    logic got;
    got = 1'b0;
    drive(4'd10, 32'd3, 32'd5);
    @(posedge clk); #1;
    bus_if.start_i = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(posedge clk); #1;
      if (bus_if.done_o === 1'b1) got = 1'b1;
    end
    n_checks++; if (got !== 1'b1) begin n_fails++; $display("FAIL b2b_timeout got no done exp done within 40 cycles"); end
    n_checks++; if (bus_if.result_o !== 32'd15) begin n_fails++; $display("FAIL b2b_mul_result got %h exp %h", bus_if.result_o, 32'd15); end
    drive(4'd0, 32'd3, 32'd4);
    @(posedge clk); #1;
    bus_if.start_i = 1'b0;
    n_checks++; if (bus_if.done_o !== 1'b1) begin n_fails++; $display("FAIL b2b_done got %b exp 1", bus_if.done_o); end
    n_checks++; if (bus_if.result_o !== 32'd7) begin n_fails++; $display("FAIL b2b_add_result got %h exp %h", bus_if.result_o, 32'd7); end
    n_checks++; if (bus_if.busy_o !== 1'b0) begin n_fails++; $display("FAIL b2b_busy got %b exp 0", bus_if.busy_o); end
    @(posedge clk); #1;
    n_checks++; if (bus_if.done_o !== 1'b0) begin n_fails++; $display("FAIL b2b_pulse got %b exp 0", bus_if.done_o); end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset = 1'b1;
    bus_if.start_i = 1'b0;
    bus_if.op_i    = 4'd0;
    bus_if.a_i     = 32'd0;
    bus_if.b_i     = 32'd0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_iterative();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
